// File: rtl/rs_alu.sv
// rs_alu: reservation station in front of the integer ALU.
// Buffers decoded ops with operand values or pending ROB tags, snoops the ALU and LSB
// result buses, and dispatches one ready op per cycle as a registered execute pulse.
// Optional build macro: RS_RR_SEL_EN selects round-robin dispatch instead of lowest-index.
// The op-type output is named type_o because "type" is a reserved word.
module rs_alu #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned OP_W    = 7,
  parameter int unsigned VAL_W   = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [VAL_W-1:0]  issue_vj,
  input  logic [VAL_W-1:0]  issue_vk,
  input  logic              issue_qj_busy,
  input  logic              issue_qk_busy,
  input  logic [ID_W-1:0]   issue_qj,
  input  logic [ID_W-1:0]   issue_qk,
  input  logic [ID_W-1:0]   issue_rob_id,
  input  logic [ADDR_W-1:0] issue_pc,
  input  logic              alu_cdb_valid,
  input  logic [ID_W-1:0]   alu_cdb_id,
  input  logic [VAL_W-1:0]  alu_cdb_val,
  input  logic              lsb_cdb_valid,
  input  logic [ID_W-1:0]   lsb_cdb_id,
  input  logic [VAL_W-1:0]  lsb_cdb_val,
  output logic              rs_full,
  output logic              execute,
  output logic [OP_W-1:0]   type_o,
  output logic [VAL_W-1:0]  val1,
  output logic [VAL_W-1:0]  val2,
  output logic [ID_W-1:0]   entry,
  output logic [ADDR_W-1:0] nowPC
);

  localparam int unsigned IdxW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy_q, busy_d, qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
  logic [RS_SIZE-1:0] ready;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [OP_W-1:0]    op_d  [RS_SIZE];
  logic [VAL_W-1:0]   vj_q  [RS_SIZE];
  logic [VAL_W-1:0]   vj_d  [RS_SIZE];
  logic [VAL_W-1:0]   vk_q  [RS_SIZE];
  logic [VAL_W-1:0]   vk_d  [RS_SIZE];
  logic [ID_W-1:0]    qj_q  [RS_SIZE];
  logic [ID_W-1:0]    qj_d  [RS_SIZE];
  logic [ID_W-1:0]    qk_q  [RS_SIZE];
  logic [ID_W-1:0]    qk_d  [RS_SIZE];
  logic [ID_W-1:0]    rob_q [RS_SIZE];
  logic [ID_W-1:0]    rob_d [RS_SIZE];
  logic [ADDR_W-1:0]  pc_q  [RS_SIZE];
  logic [ADDR_W-1:0]  pc_d  [RS_SIZE];

  logic              exec_q, exec_d;
  logic [OP_W-1:0]   type_q, type_d;
  logic [VAL_W-1:0]  val1_q, val1_d, val2_q, val2_d;
  logic [ID_W-1:0]   entry_q, entry_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;

  logic              free_found, disp_found;
  logic [IdxW-1:0]   free_idx, disp_idx;
  logic              in_qjb, in_qkb;
  logic [VAL_W-1:0]  in_vj, in_vk;

`ifdef RS_RR_SEL_EN
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  assign rs_full = &busy_q;
  assign execute = exec_q;
  assign type_o  = type_q;
  assign val1    = val1_q;
  assign val2    = val2_q;
  assign entry   = entry_q;
  assign nowPC   = pc_out_q;

  // Ready vector and lowest-index free slot, both from registered state only.
  always_comb begin
    ready      = busy_q & ~qj_busy_q & ~qk_busy_q;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // Dispatch selection: later loop iterations override, so the first candidate in order wins.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
`ifdef RS_RR_SEL_EN
    for (int k = RS_SIZE; k >= 1; k--) begin
      if (ready[rr_ptr_q + IdxW'(k)]) begin
        disp_found = 1'b1;
        disp_idx   = rr_ptr_q + IdxW'(k);
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        disp_found = 1'b1;
        disp_idx   = IdxW'(i);
      end
    end
`endif
  end

  // Same-cycle bypass of an incoming pending operand from either CDB; ALU bus wins a tie.
  always_comb begin
    in_qjb = issue_qj_busy;
    in_vj  = issue_vj;
    if (issue_qj_busy && alu_cdb_valid && alu_cdb_id == issue_qj) begin
      in_qjb = 1'b0;
      in_vj  = alu_cdb_val;
    end else if (issue_qj_busy && lsb_cdb_valid && lsb_cdb_id == issue_qj) begin
      in_qjb = 1'b0;
      in_vj  = lsb_cdb_val;
    end
    in_qkb = issue_qk_busy;
    in_vk  = issue_vk;
    if (issue_qk_busy && alu_cdb_valid && alu_cdb_id == issue_qk) begin
      in_qkb = 1'b0;
      in_vk  = alu_cdb_val;
    end else if (issue_qk_busy && lsb_cdb_valid && lsb_cdb_id == issue_qk) begin
      in_qkb = 1'b0;
      in_vk  = lsb_cdb_val;
    end
  end

  // Next state: flush wins; otherwise wakeup, dispatch and allocation all apply together.
  always_comb begin
    busy_d    = busy_q;
    qj_busy_d = qj_busy_q;
    qk_busy_d = qk_busy_q;
    op_d      = op_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    rob_d     = rob_q;
    pc_d      = pc_q;
    exec_d    = 1'b0;
    type_d    = type_q;
    val1_d    = val1_q;
    val2_d    = val2_q;
    entry_d   = entry_q;
    pc_out_d  = pc_out_q;
`ifdef RS_RR_SEL_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && qj_busy_q[i]) begin
          if (alu_cdb_valid && alu_cdb_id == qj_q[i]) begin
            qj_busy_d[i] = 1'b0;
            vj_d[i]      = alu_cdb_val;
          end else if (lsb_cdb_valid && lsb_cdb_id == qj_q[i]) begin
            qj_busy_d[i] = 1'b0;
            vj_d[i]      = lsb_cdb_val;
          end
        end
        if (busy_q[i] && qk_busy_q[i]) begin
          if (alu_cdb_valid && alu_cdb_id == qk_q[i]) begin
            qk_busy_d[i] = 1'b0;
            vk_d[i]      = alu_cdb_val;
          end else if (lsb_cdb_valid && lsb_cdb_id == qk_q[i]) begin
            qk_busy_d[i] = 1'b0;
            vk_d[i]      = lsb_cdb_val;
          end
        end
      end
      if (disp_found) begin
        busy_d[disp_idx] = 1'b0;
        exec_d           = 1'b1;
        type_d           = op_q[disp_idx];
        val1_d           = vj_q[disp_idx];
        val2_d           = vk_q[disp_idx];
        entry_d          = rob_q[disp_idx];
        pc_out_d         = pc_q[disp_idx];
`ifdef RS_RR_SEL_EN
        rr_ptr_d         = disp_idx;
`endif
      end
      // free_idx is never the dispatching slot, so a freed entry is not reused this cycle.
      if (issue_valid && !rs_full && free_found) begin
        busy_d[free_idx]    = 1'b1;
        qj_busy_d[free_idx] = in_qjb;
        qk_busy_d[free_idx] = in_qkb;
        op_d[free_idx]      = issue_op;
        vj_d[free_idx]      = in_vj;
        vk_d[free_idx]      = in_vk;
        qj_d[free_idx]      = issue_qj;
        qk_d[free_idx]      = issue_qk;
        rob_d[free_idx]     = issue_rob_id;
        pc_d[free_idx]      = issue_pc;
      end
    end
  end

  // Control state and registered outputs, cleared asynchronously and frozen while rdy_in is low.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      busy_q    <= '0;
      qj_busy_q <= '0;
      qk_busy_q <= '0;
      exec_q    <= 1'b0;
      type_q    <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      entry_q   <= '0;
      pc_out_q  <= '0;
`ifdef RS_RR_SEL_EN
      rr_ptr_q  <= '0;
`endif
    end else if (rdy_in) begin
      busy_q    <= busy_d;
      qj_busy_q <= qj_busy_d;
      qk_busy_q <= qk_busy_d;
      exec_q    <= exec_d;
      type_q    <= type_d;
      val1_q    <= val1_d;
      val2_q    <= val2_d;
      entry_q   <= entry_d;
      pc_out_q  <= pc_out_d;
`ifdef RS_RR_SEL_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  // Entry payload; only meaningful while the busy bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy_in) begin
      op_q  <= op_d;
      vj_q  <= vj_d;
      vk_q  <= vk_d;
      qj_q  <= qj_d;
      qk_q  <= qk_d;
      rob_q <= rob_d;
      pc_q  <= pc_d;
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu (default fixed-priority build).
module tb_rs_alu;

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  id;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic [6:0]  issue_op = '0;
  logic [31:0] issue_vj = '0, issue_vk = '0;
  logic        issue_qj_busy = 1'b0, issue_qk_busy = 1'b0;
  logic [3:0]  issue_qj = '0, issue_qk = '0, issue_rob_id = '0;
  logic [31:0] issue_pc = '0;
  logic        alu_cdb_valid = 1'b0, lsb_cdb_valid = 1'b0;
  logic [3:0]  alu_cdb_id = '0, lsb_cdb_id = '0;
  logic [31:0] alu_cdb_val = '0, lsb_cdb_val = '0;
  logic        rs_full, execute;
  logic [6:0]  type_o;
  logic [31:0] val1, val2, nowPC;
  logic [3:0]  entry;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t exp_e, act_e;

  rs_alu dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rob_id(issue_rob_id), .issue_pc(issue_pc),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_id(alu_cdb_id), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_id(lsb_cdb_id), .lsb_cdb_val(lsb_cdb_val),
    .rs_full(rs_full), .execute(execute), .type_o(type_o), .val1(val1), .val2(val2),
    .entry(entry), .nowPC(nowPC)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Monitor: every rdy-qualified execute cycle must match the oldest expected dispatch.
  always @(negedge clk) begin
    if (!rst_in && rdy_in && execute) begin
      checks++;
      act_e = {type_o, val1, val2, entry, nowPC};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dispatch got %h want none", act_e);
      end else begin
        exp_e = sb.pop_front();
        if (act_e !== exp_e) begin
          errors++;
          $display("FAIL dispatch_fields got %h want %h", act_e, exp_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [6:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjb, input logic [3:0] qj, input logic qkb,
                             input logic [3:0] qk, input logic [3:0] rob,
                             input logic [31:0] pc);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_vj      = vj;
    issue_vk      = vk;
    issue_qj_busy = qjb;
    issue_qj      = qj;
    issue_qk_busy = qkb;
    issue_qk      = qk;
    issue_rob_id  = rob;
    issue_pc      = pc;
  endtask

  task automatic push(input logic [6:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [3:0] id, input logic [31:0] pc);
    exp_t e;
    e = {op, v1, v2, id, pc};
    sb.push_back(e);
  endtask

  initial begin
    // Reset state
    #3;
    chk("reset_execute", 64'(execute), 64'd0);
    chk("reset_rs_full", 64'(rs_full), 64'd0);
    chk("reset_fields", 64'({type_o, entry, val1}), 64'd0);
    tick();
    tick();
    rst_in = 1'b0;
    tick();

    // Ready issue: dispatch one edge after the issue edge, for exactly one cycle
    drive_issue(7'h01, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'h100);
    push(7'h01, 32'd5, 32'd7, 4'd3, 32'h100);
    tick();
    issue_valid = 1'b0;
    chk("ready_no_early", 64'(execute), 64'd0);
    tick();
    chk("ready_execute", 64'(execute), 64'd1);
    tick();
    chk("ready_pulse_end", 64'(execute), 64'd0);

    // Wakeup from the ALU bus two cycles after issue
    drive_issue(7'h11, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4, 32'h200);
    push(7'h11, 32'hDEAD, 32'd1, 4'd4, 32'h200);
    tick();
    issue_valid = 1'b0;
    tick();
    chk("wake_wait0", 64'(execute), 64'd0);
    alu_cdb_valid = 1'b1;
    alu_cdb_id    = 4'd2;
    alu_cdb_val   = 32'hDEAD;
    tick();
    alu_cdb_valid = 1'b0;
    chk("wake_wait1", 64'(execute), 64'd0);
    tick();
    chk("wake_execute", 64'(execute), 64'd1);

    // Issue bypass from the LSB bus in the same cycle
    drive_issue(7'h22, 32'd11, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd6, 32'h300);
    lsb_cdb_valid = 1'b1;
    lsb_cdb_id    = 4'd5;
    lsb_cdb_val   = 32'd9;
    push(7'h22, 32'd11, 32'd9, 4'd6, 32'h300);
    tick();
    issue_valid   = 1'b0;
    lsb_cdb_valid = 1'b0;
    tick();
    chk("bypass_execute", 64'(execute), 64'd1);
    tick();

    // Fill all 8 entries waiting on tag 1, then a dropped 9th, then wake all at once
    for (int i = 0; i < 8; i++) begin
      drive_issue(7'h03, 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 4'(8 + i), 32'h400 + 32'(4 * i));
      tick();
    end
    chk("full_set", 64'(rs_full), 64'd1);
    drive_issue(7'h04, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'h500);
    tick();
    issue_valid = 1'b0;
    chk("full_drop_full", 64'(rs_full), 64'd1);
    chk("full_drop_noexec", 64'(execute), 64'd0);
    alu_cdb_valid = 1'b1;
    alu_cdb_id    = 4'd1;
    alu_cdb_val   = 32'h1111;
    for (int i = 0; i < 8; i++) push(7'h03, 32'h1111, 32'(i), 4'(8 + i), 32'h400 + 32'(4 * i));
    tick();
    alu_cdb_valid = 1'b0;
    chk("full_still_full", 64'(rs_full), 64'd1);
    tick();
    chk("full_first_exec", 64'(execute), 64'd1);
    chk("full_falls", 64'(rs_full), 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("full_burst_exec", 64'(execute), 64'd1);
    end
    tick();
    chk("full_burst_end", 64'(execute), 64'd0);

    // Flush with a concurrent issue while 4 entries wait on tag 6
    for (int i = 0; i < 4; i++) begin
      drive_issue(7'h05, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'(1 + i), 32'h600);
      tick();
    end
    drive_issue(7'h06, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 32'h700);
    flush = 1'b1;
    tick();
    flush       = 1'b0;
    issue_valid = 1'b0;
    chk("flush_rs_full", 64'(rs_full), 64'd0);
    chk("flush_noexec", 64'(execute), 64'd0);
    alu_cdb_valid = 1'b1;
    alu_cdb_id    = 4'd6;
    alu_cdb_val   = 32'h6666;
    tick();
    alu_cdb_valid = 1'b0;
    tick();
    chk("flush_gone0", 64'(execute), 64'd0);
    tick();
    chk("flush_gone1", 64'(execute), 64'd0);

    // Stall with a ready entry, then stall again while execute is high
    drive_issue(7'h07, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'h800);
    push(7'h07, 32'h55, 32'h66, 4'd9, 32'h800);
    tick();
    issue_valid = 1'b0;
    rdy_in      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_noexec", 64'(execute), 64'd0);
      chk("stall_frozen", 64'({entry, val1}), 64'({4'd15, 32'h1111}));
    end
    rdy_in = 1'b1;
    tick();
    chk("stall_release", 64'(execute), 64'd1);
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_hold_exec", 64'({execute, entry, val2}), 64'({1'b1, 4'd9, 32'h66}));
    end
    rdy_in = 1'b1;
    tick();
    chk("stall_pulse_end", 64'(execute), 64'd0);

    // Asynchronous reset while execute is high
    drive_issue(7'h08, 32'h77, 32'h88, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'h900);
    tick();
    issue_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_exec", 64'(execute), 64'd1);
    #1 rst_in = 1'b1;
    #1;
    chk("async_reset_exec", 64'(execute), 64'd0);
    chk("async_reset_fields", 64'({entry, val1}), 64'd0);
    tick();
    rst_in = 1'b0;
    tick();
    tick();
    chk("post_reset_idle", 64'({execute, rs_full}), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station for the integer ALU in the out-of-order core. It buffers decoded ALU/branch operations together with their operand values or ROB tags. It snoops the ALU and load/store result buses to wake up waiting operands. Each cycle it dispatches at most one operation with both operands ready to the ALU, as a registered one-cycle `execute` pulse with type, operands, ROB entry and PC.

## Interface
- `RS_SIZE`, 8: number of entries; power of two, at least 2.
- `OP_W`, 7: op-type width. [2:0] is the class, [5:3] is funct3, [6] is the extra selector.
- `VAL_W`, 32: operand/result width.
- `ID_W`, 4: ROB tag width.
- `ADDR_W`, 32: PC width.

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global enable. When low, all state and outputs hold.
- `flush` in 1: misprediction clear from the ROB.
- `issue_valid` in 1: insert one operation this cycle.
- `issue_op` in OP_W: op type.
- `issue_vj`, `issue_vk` in VAL_W: operand values, meaningful when the matching busy bit is 0.
- `issue_qj_busy`, `issue_qk_busy` in 1: operand still pending on a ROB tag.
- `issue_qj`, `issue_qk` in ID_W: producing ROB tags.
- `issue_rob_id` in ID_W: destination ROB entry.
- `issue_pc` in ADDR_W: PC value forwarded unchanged to the ALU.
- `alu_cdb_valid` in 1, `alu_cdb_id` in ID_W, `alu_cdb_val` in VAL_W: ALU result broadcast.
- `lsb_cdb_valid` in 1, `lsb_cdb_id` in ID_W, `lsb_cdb_val` in VAL_W: load/store result broadcast.
- `rs_full` out 1: no free entry, derived from registered busy bits.
- `execute` out 1: one-cycle dispatch strobe to the ALU.
- `type` out OP_W, `val1` out VAL_W, `val2` out VAL_W, `entry` out ID_W, `nowPC` out ADDR_W: dispatched operation fields.

## Operation
- Per-entry state: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, rob_id, pc.
- **Allocation:** when `issue_valid` is high and `rs_full` is 0, the lowest-index free entry is written.
  - `issue_valid` while `rs_full` is high is a protocol error. The request is dropped and no state changes.
- **Issue bypass:** an incoming operand with busy=1 whose tag matches a valid CDB in the same cycle is stored as ready, with the CDB value.
  - The ALU bus has priority if both CDBs carry the same tag. This is a protocol error and is never expected.
- **Wakeup:** for every busy entry, qj_busy/qk_busy equal to 1 with a tag matching a valid CDB causes the value to be captured and busy cleared. Both CDBs are snooped in parallel every cycle.
- **Ready:** an entry is ready when busy=1, qj_busy=0 and qk_busy=0, evaluated on registered state.
- **Dispatch:** if any entry is ready, one is selected at the edge.
  - Its fields are registered onto the outputs, `execute` is set to 1 and the entry's busy bit is cleared.
  - Otherwise `execute` is set to 0; the other outputs hold their last values.
- **Flush:** all busy bits are cleared and `execute` is set to 0 at the edge.
  - Flush overrides issue, wakeup and dispatch in the same cycle.
- Reset values:
  - All busy bits 0, so `rs_full` is 0.
  - `execute` 0; `type`, `val1`, `val2`, `entry` and `nowPC` all 0.

## Timing
- All outputs are registered except `rs_full`, which is combinational from the busy bits only (no dependence on `issue_valid`).
- Minimum latency:
  - An operation issued with both operands ready at edge N is dispatched at edge N+1, so `execute` is high during cycle N+1..N+2.
  - An operand woken at edge N makes the entry dispatchable at edge N+1.
- Issue and dispatch in the same cycle are both performed.
  - An entry freed by dispatch is not reusable until the next cycle.
  - With RS_SIZE entries all busy and one dispatching, `rs_full` remains 1 for that cycle.
- `execute` is high for exactly one `rdy_in`-qualified cycle per dispatch. Back-to-back dispatches keep `execute` high continuously, with new fields each cycle.
- With `rdy_in` low, nothing updates, including CDB capture. Upstream and the ALU are frozen by the same signal.
- Asserting `rst_in` mid-operation clears immediately and asynchronously. Entries are lost and `execute` drops without waiting for a clock.

## Configuration
- `RS_RR_SEL_EN` defined: dispatch uses a round-robin pointer.
  - The search starts at the index after the last dispatched entry and wraps at RS_SIZE-1 to 0.
  - The pointer resets to 0 and is not changed by flush.
- `RS_RR_SEL_EN` undefined: dispatch selects the lowest-index ready entry (fixed priority). Allocation is lowest-index free in both builds.

## Test plan
- **Reset and ready issue:** reset, then issue addi with `issue_vj`=5, `issue_vk`=7, neither busy, `issue_rob_id`=3, `issue_pc`=0x100. Expect `execute`=1 one cycle later with `val1`=5, `val2`=7, `entry`=3, `nowPC`=0x100; `execute`=0 the following cycle.
- **Wakeup:** issue with qj_busy, `issue_qj`=2. Two cycles later drive `alu_cdb_valid` with `alu_cdb_id`=2, `alu_cdb_val`=0xDEAD. Expect dispatch at the next edge with `val1`=0xDEAD; no dispatch before.
- **Issue bypass:** issue with qk_busy, `issue_qk`=5, while `lsb_cdb_valid` with `lsb_cdb_id`=5, `lsb_cdb_val`=9 in the same cycle. Expect dispatch with `val2`=9 one cycle later.
- **Full and simultaneous:** fill 8 entries all waiting on tag 1. Expect `rs_full`=1 and a 9th `issue_valid` dropped. Broadcast tag 1: expect 8 consecutive `execute` cycles, with `rs_full` falling after the first.
- **Flush:** flush together with `issue_valid` while 4 entries wait. Expect all entries cleared, the new issue dropped, and `rs_full`=0.
- **Stall:** hold `rdy_in`=0 for 3 cycles with a ready entry. Expect `execute` and all fields frozen, dispatching only after `rdy_in` returns to 1.
